// File: rtl/mem_pkg.sv
// Shared types for the memory-access stage: funct3 size encodings, FSM states, byte-lane constants.
package mem_pkg;

  typedef enum logic [2:0] {
    SZ_B  = 3'd0,
    SZ_H  = 3'd1,
    SZ_W  = 3'd2,
    SZ_BU = 3'd4,
    SZ_HU = 3'd5
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mem_state_e;

  localparam int         LANES    = 4;
  localparam logic [3:0] BE_NONE  = 4'b0000;
  localparam logic [3:0] BE_BYTE  = 4'b0001;
  localparam logic [3:0] BE_HALF  = 4'b0011;
  localparam logic [3:0] BE_WORD  = 4'b1111;

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane logic: store BE/lane replication, load lane extract with sign/zero extension.
// Offsets that cannot hold the access are aligned down; misaligned flags the original offset.
module mem_align
  import mem_pkg::*;
(
  input  mem_size_e   size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [1:0]  eff_off,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [31:0] lane;

  always_comb begin
    eff_off    = addr_lo;
    be         = BE_NONE;
    wdata      = store_data;
    misaligned = 1'b0;
    case (size)
      SZ_B, SZ_BU: begin
        eff_off = addr_lo;
        be      = BE_BYTE << addr_lo;
        wdata   = {LANES{store_data[7:0]}};
      end
      SZ_H, SZ_HU: begin
        misaligned = addr_lo[0];
        eff_off    = {addr_lo[1], 1'b0};
        be         = BE_HALF << {addr_lo[1], 1'b0};
        wdata      = {2{store_data[15:0]}};
      end
      default: begin
        misaligned = |addr_lo;
        eff_off    = 2'b00;
        be         = BE_WORD;
        wdata      = store_data;
      end
    endcase
  end

  // Shift the selected lane down to bit 0 before extending.
  assign lane = rdata >> {eff_off, 3'b000};

  always_comb begin
    load_data = lane;
    case (size)
      SZ_B:    load_data = {{24{lane[7]}}, lane[7:0]};
      SZ_BU:   load_data = {24'b0, lane[7:0]};
      SZ_H:    load_data = {{16{lane[15]}}, lane[15:0]};
      SZ_HU:   load_data = {16'b0, lane[15:0]};
      default: load_data = lane;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: ALU ops reach writeback 1 cycle after accept, loads 1 cycle after DMEM_ACK; stores retire on ack.
// Writeback payload holds while WB_HAZARD=1; MEM_MISALIGNED trapping is built only with MEM_ALIGN_CHECK_EN.
module mem_stage
  import mem_pkg::*;
#(
  parameter int XCNT = 32,
  parameter int XLEN = 32
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic                    EX_VALID,
  output logic                    MEM_READY,
  input  logic                    EX_LOAD,
  input  logic                    EX_STORE,
  input  logic [2:0]              EX_SIZE,
  input  logic [$clog2(XCNT)-1:0] EX_RD,
  input  logic [XLEN-1:0]         EX_RESULT,
  input  logic [XLEN-1:0]         EX_STORE_DATA,
  output logic                    DMEM_REQ,
  output logic                    DMEM_WE,
  output logic [XLEN-1:0]         DMEM_ADDR,
  output logic [XLEN/8-1:0]       DMEM_BE,
  output logic [XLEN-1:0]         DMEM_WDATA,
  input  logic [XLEN-1:0]         DMEM_RDATA,
  input  logic                    DMEM_ACK,
  output logic                    WB_ENABLED,
  output logic [$clog2(XCNT)-1:0] WB_WRITE_SEL,
  output logic [XLEN-1:0]         WB_WRITE_DATA,
  input  logic                    WB_HAZARD,
  output logic                    MEM_MISALIGNED
);

  localparam int SELW = $clog2(XCNT);

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  mem_state_e        state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              we_q, we_d;
  mem_size_e         size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic [SELW-1:0]   rd_q, rd_d;
  logic              wb_en_q, wb_en_d;
  logic [SELW-1:0]   wb_sel_q, wb_sel_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic              mis_q, mis_d;

  logic              acc, accept, is_mem, mis_trap;
  mem_size_e         al_size;
  logic [1:0]        al_off, al_eff;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata, al_load;
  logic              al_mis;

  // One aligner serves both paths: EX fields at accept, registered size/offset while waiting for ack.
  assign acc     = (state_q == ACCESS);
  assign al_size = acc ? size_q : mem_size_e'(EX_SIZE);
  assign al_off  = acc ? off_q : EX_RESULT[1:0];

  mem_align u_align (
    .size       (al_size),
    .addr_lo    (al_off),
    .store_data (EX_STORE_DATA),
    .rdata      (DMEM_RDATA),
    .eff_off    (al_eff),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .misaligned (al_mis)
  );

  assign MEM_READY = (state_q == IDLE) | ((state_q == RESP) & ~WB_HAZARD);
  assign accept    = EX_VALID & MEM_READY;
  assign is_mem    = EX_LOAD | EX_STORE;
  assign mis_trap  = ALIGN_CHK & al_mis;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    size_d    = size_q;
    off_d     = off_q;
    rd_d      = rd_q;
    wb_en_d   = wb_en_q;
    wb_sel_d  = wb_sel_q;
    wb_data_d = wb_data_q;
    mis_d     = 1'b0;

    case (state_q)
      ACCESS: begin
        if (DMEM_ACK) begin
          if (we_q) begin
            state_d = IDLE;
          end else begin
            state_d   = RESP;
            wb_en_d   = |rd_q;
            wb_sel_d  = rd_q;
            wb_data_d = al_load;
          end
        end
      end
      RESP: begin
        if (!WB_HAZARD) begin
          state_d = IDLE;
          wb_en_d = 1'b0;
        end
      end
      default: begin
      end
    endcase

    // Accept overrides the RESP drain so back-to-back ops replace the consumed payload.
    if (accept) begin
      wb_en_d = 1'b0;
      if (is_mem && mis_trap) begin
        state_d = IDLE;
        mis_d   = 1'b1;
      end else if (is_mem) begin
        state_d = ACCESS;
        addr_d  = {EX_RESULT[XLEN-1:2], 2'b00};
        be_d    = al_be;
        wdata_d = al_wdata;
        we_d    = EX_STORE;
        size_d  = al_size;
        off_d   = al_eff;
        rd_d    = EX_RD;
      end else begin
        state_d   = RESP;
        wb_en_d   = |EX_RD;
        wb_sel_d  = EX_RD;
        wb_data_d = EX_RESULT;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      size_q    <= SZ_B;
      off_q     <= '0;
      rd_q      <= '0;
      wb_en_q   <= 1'b0;
      wb_sel_q  <= '0;
      wb_data_q <= '0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      size_q    <= size_d;
      off_q     <= off_d;
      rd_q      <= rd_d;
      wb_en_q   <= wb_en_d;
      wb_sel_q  <= wb_sel_d;
      wb_data_q <= wb_data_d;
      mis_q     <= mis_d;
    end
  end

  assign DMEM_REQ       = acc;
  assign DMEM_WE        = acc & we_q;
  assign DMEM_ADDR      = acc ? addr_q : '0;
  assign DMEM_BE        = acc ? be_q : '0;
  assign DMEM_WDATA     = acc ? wdata_q : '0;
  assign WB_ENABLED     = wb_en_q;
  assign WB_WRITE_SEL   = wb_sel_q;
  assign WB_WRITE_DATA  = wb_data_q;
  assign MEM_MISALIGNED = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU/load/store paths, lane logic, writeback hold, alignment, async reset.
module tb_mem_stage;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        EX_VALID, EX_LOAD, EX_STORE;
  logic [2:0]  EX_SIZE;
  logic [4:0]  EX_RD;
  logic [31:0] EX_RESULT, EX_STORE_DATA;
  logic        MEM_READY, DMEM_REQ, DMEM_WE, DMEM_ACK;
  logic [31:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
  logic [3:0]  DMEM_BE;
  logic        WB_ENABLED, WB_HAZARD, MEM_MISALIGNED;
  logic [4:0]  WB_WRITE_SEL;
  logic [31:0] WB_WRITE_DATA;

  int n_chk  = 0;
  int n_fail = 0;

  mem_stage #(.XCNT(32), .XLEN(32)) dut (
    .CLK(CLK), .RSTN(RSTN), .EX_VALID(EX_VALID), .MEM_READY(MEM_READY),
    .EX_LOAD(EX_LOAD), .EX_STORE(EX_STORE), .EX_SIZE(EX_SIZE), .EX_RD(EX_RD),
    .EX_RESULT(EX_RESULT), .EX_STORE_DATA(EX_STORE_DATA),
    .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR), .DMEM_BE(DMEM_BE),
    .DMEM_WDATA(DMEM_WDATA), .DMEM_RDATA(DMEM_RDATA), .DMEM_ACK(DMEM_ACK),
    .WB_ENABLED(WB_ENABLED), .WB_WRITE_SEL(WB_WRITE_SEL), .WB_WRITE_DATA(WB_WRITE_DATA),
    .WB_HAZARD(WB_HAZARD), .MEM_MISALIGNED(MEM_MISALIGNED)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic op(input logic ld, input logic st, input logic [2:0] sz,
                    input logic [4:0] rd, input logic [31:0] res, input logic [31:0] sd);
    EX_VALID = 1'b1; EX_LOAD = ld; EX_STORE = st; EX_SIZE = sz;
    EX_RD = rd; EX_RESULT = res; EX_STORE_DATA = sd;
  endtask

  task automatic idle_ex();
    EX_VALID = 1'b0; EX_LOAD = 1'b0; EX_STORE = 1'b0;
  endtask

  initial begin
    RSTN = 1'b0; WB_HAZARD = 1'b0; DMEM_ACK = 1'b0; DMEM_RDATA = '0;
    EX_SIZE = '0; EX_RD = '0; EX_RESULT = '0; EX_STORE_DATA = '0;
    idle_ex();
    #12;
    chk("rst_ready", MEM_READY, 1);
    chk("rst_req", DMEM_REQ, 0);
    chk("rst_wben", WB_ENABLED, 0);
    chk("rst_mis", MEM_MISALIGNED, 0);
    chk("rst_wbdata", WB_WRITE_DATA, 0);
    #1 RSTN = 1'b1;

    // ALU op rd=5
    step();
    op(0, 0, 3'd0, 5'd5, 32'hDEAD_BEEF, 32'h0);
    #1 chk("alu_ready", MEM_READY, 1);
    step(); idle_ex();
    chk("alu_wben", WB_ENABLED, 1);
    chk("alu_sel", WB_WRITE_SEL, 5);
    chk("alu_data", WB_WRITE_DATA, 32'hDEAD_BEEF);
    chk("alu_noreq", DMEM_REQ, 0);
    step();
    chk("alu_drain", WB_ENABLED, 0);

    // LB 0x103, ack k=3, then 3 cycles of WB_HAZARD with an ALU op waiting
    op(1, 0, 3'd0, 5'd7, 32'h0000_0103, 32'h0);
    step(); idle_ex();
    chk("lb_req", DMEM_REQ, 1);
    chk("lb_we", DMEM_WE, 0);
    chk("lb_addr", DMEM_ADDR, 32'h100);
    chk("lb_be", DMEM_BE, 4'b1000);
    chk("lb_busy", MEM_READY, 0);
    step();
    chk("lb_hold_req", DMEM_REQ, 1);
    step();
    DMEM_ACK = 1'b1; DMEM_RDATA = 32'h8012_3456;
    step();
    DMEM_ACK = 1'b0; DMEM_RDATA = '0;
    chk("lb_wben", WB_ENABLED, 1);
    chk("lb_sel", WB_WRITE_SEL, 7);
    chk("lb_data", WB_WRITE_DATA, 32'hFFFF_FF80);
    chk("lb_req_drop", DMEM_REQ, 0);
    WB_HAZARD = 1'b1;
    op(0, 0, 3'd0, 5'd9, 32'h0000_0011, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hz_ready", MEM_READY, 0);
      chk("hz_wben", WB_ENABLED, 1);
      chk("hz_data", WB_WRITE_DATA, 32'hFFFF_FF80);
      chk("hz_sel", WB_WRITE_SEL, 7);
      step();
    end
    WB_HAZARD = 1'b0;
    #1 chk("hz_release", MEM_READY, 1);
    chk("hz_last_data", WB_WRITE_DATA, 32'hFFFF_FF80);
    step(); idle_ex();
    chk("b2b_wben", WB_ENABLED, 1);
    chk("b2b_sel", WB_WRITE_SEL, 9);
    chk("b2b_data", WB_WRITE_DATA, 32'h0000_0011);
    step();

    // LHU 0x102, ack k=1
    op(1, 0, 3'd5, 5'd3, 32'h0000_0102, 32'h0);
    step(); idle_ex();
    chk("lhu_be", DMEM_BE, 4'b1100);
    DMEM_ACK = 1'b1; DMEM_RDATA = 32'h8765_4321;
    step(); DMEM_ACK = 1'b0;
    chk("lhu_data", WB_WRITE_DATA, 32'h0000_8765);
    step();

    // LH 0x100 sign-extends
    op(1, 0, 3'd1, 5'd4, 32'h0000_0100, 32'h0);
    step(); idle_ex();
    DMEM_ACK = 1'b1; DMEM_RDATA = 32'h1234_F00D;
    step(); DMEM_ACK = 1'b0;
    chk("lh_data", WB_WRITE_DATA, 32'hFFFF_F00D);
    step();

    // SH 0x202
    op(0, 1, 3'd1, 5'd0, 32'h0000_0202, 32'hABCD_1234);
    step(); idle_ex();
    chk("sh_we", DMEM_WE, 1);
    chk("sh_addr", DMEM_ADDR, 32'h200);
    chk("sh_be", DMEM_BE, 4'b1100);
    chk("sh_wdata", DMEM_WDATA, 32'h1234_1234);
    DMEM_ACK = 1'b1;
    step(); DMEM_ACK = 1'b0;
    chk("sh_nowb", WB_ENABLED, 0);
    chk("sh_idle", MEM_READY, 1);
    chk("sh_req_drop", DMEM_REQ, 0);

    // SB 0x001
    op(0, 1, 3'd0, 5'd0, 32'h0000_0001, 32'h0000_00A5);
    step(); idle_ex();
    chk("sb_be", DMEM_BE, 4'b0010);
    chk("sb_wdata", DMEM_WDATA, 32'hA5A5_A5A5);
    DMEM_ACK = 1'b1;
    step(); DMEM_ACK = 1'b0;

    // LW rd=0 accesses memory but never writes back
    op(1, 0, 3'd2, 5'd0, 32'h0000_0010, 32'h0);
    step(); idle_ex();
    chk("lw0_req", DMEM_REQ, 1);
    DMEM_ACK = 1'b1; DMEM_RDATA = 32'hCAFE_F00D;
    step(); DMEM_ACK = 1'b0;
    chk("lw0_nowb", WB_ENABLED, 0);
    step();

    // LW 0x6
    op(1, 0, 3'd2, 5'd6, 32'h0000_0006, 32'h0);
    step(); idle_ex();
`ifdef MEM_ALIGN_CHECK_EN
    chk("lwmis_noreq", DMEM_REQ, 0);
    chk("lwmis_flag", MEM_MISALIGNED, 1);
    chk("lwmis_ready", MEM_READY, 1);
    step();
    chk("lwmis_pulse", MEM_MISALIGNED, 0);
    chk("lwmis_nowb", WB_ENABLED, 0);
`else
    chk("lwal_addr", DMEM_ADDR, 32'h4);
    chk("lwal_be", DMEM_BE, 4'hF);
    chk("lwal_flag", MEM_MISALIGNED, 0);
    DMEM_ACK = 1'b1; DMEM_RDATA = 32'h0102_0304;
    step(); DMEM_ACK = 1'b0;
    chk("lwal_data", WB_WRITE_DATA, 32'h0102_0304);
    step();
`endif

    // Stray ack in IDLE is ignored
    DMEM_ACK = 1'b1;
    step(); DMEM_ACK = 1'b0;
    chk("stray_req", DMEM_REQ, 0);
    chk("stray_wb", WB_ENABLED, 0);
    chk("stray_ready", MEM_READY, 1);

    // Async reset during ACCESS, then late ack
    op(1, 0, 3'd2, 5'd3, 32'h0000_0020, 32'h0);
    step(); idle_ex();
    chk("ar_req", DMEM_REQ, 1);
    #1 RSTN = 1'b0;
    #1 chk("ar_req_drop", DMEM_REQ, 0);
    chk("ar_ready", MEM_READY, 1);
    #2 RSTN = 1'b1;
    step();
    DMEM_ACK = 1'b1; DMEM_RDATA = 32'h5555_AAAA;
    step(); DMEM_ACK = 1'b0;
    chk("ar_late_wb", WB_ENABLED, 0);
    chk("ar_late_req", DMEM_REQ, 0);
    chk("ar_late_data", WB_WRITE_DATA, 32'h0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
